// File: rtl/pipe_addsub.sv
// ============================================================================
// Module      : pipe_addsub
// Description : Pipelined unsigned add/subtract unit with valid/ready flow
//               control on both sides. Results move through DEPTH stages
//               that collapse bubbles and stall under backpressure without
//               dropping or duplicating data. Reports carry/borrow on ovf,
//               tracks the number of occupied stages and supports a
//               synchronous flush.
//               Optional macro PIPE_ADDSUB_SAT_EN: saturate on carry
//               (all ones) or borrow (zero) instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================

`default_nettype none

module pipe_addsub #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         op,
    input  logic [W-1:0]                 a,
    input  logic [W-1:0]                 b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W-1:0]                 y,
    output logic                         ovf,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int c_OCC_W = $clog2(DEPTH + 1);

    // ------------------------------------------------------------------------
    // Pipeline state: one valid bit, one result word and one ovf bit per stage
    // ------------------------------------------------------------------------
    logic [DEPTH-1:0]   r_vld;
    logic [W-1:0]       r_res [DEPTH];
    logic [DEPTH-1:0]   r_ovf;
    logic [c_OCC_W-1:0] r_occ;

    logic [DEPTH-1:0]   w_load;      // stage i may take new contents this cycle
    logic [DEPTH-1:0]   w_vld_nxt;   // valid bits after the coming edge
    logic [c_OCC_W-1:0] w_occ_nxt;   // popcount of w_vld_nxt
    logic               w_accept;    // input handshake completes at this edge

    logic [W:0]         w_raw;       // full-width sum or difference
    logic               w_carry;     // carry-out (add) or borrow (sub)
    logic [W-1:0]       w_res;       // result word written into stage 0

    // Stage-0 arithmetic: one extra bit exposes carry-out, or borrow for a < b
    always_comb begin
        w_raw = '0;
        if (op) begin
            w_raw = {1'b0, a} - {1'b0, b};
        end else begin
            w_raw = {1'b0, a} + {1'b0, b};
        end
        w_carry = w_raw[W];
    end

`ifdef PIPE_ADDSUB_SAT_EN
    // Clamp to the rail in the direction of the overflow
    always_comb begin
        w_res = w_raw[W-1:0];
        if (w_carry) begin
            w_res = op ? {W{1'b0}} : {W{1'b1}};
        end
    end
`else
    // Plain modulo-2^W result
    always_comb begin
        w_res = w_raw[W-1:0];
    end
`endif

    // Load chain, last stage first: a stage loads if it is empty or the
    // stage in front of it moves on (last stage: downstream takes it)
    always_comb begin
        w_load = '0;
        w_load[DEPTH-1] = !r_vld[DEPTH-1] || out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_load[i] = !r_vld[i] || w_load[i+1];
        end
    end

    // Input handshake; reset and flush both refuse new work
    always_comb begin
        in_ready = rst_n && !flush && w_load[0];
        w_accept = in_valid && in_ready;
    end

    // Next valid bits: loading stages copy their predecessor's valid bit,
    // stalled stages keep theirs, flush empties everything
    always_comb begin
        w_vld_nxt = r_vld;
        if (flush) begin
            w_vld_nxt = '0;
        end else begin
            if (w_load[0]) begin
                w_vld_nxt[0] = w_accept;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_load[i]) begin
                    w_vld_nxt[i] = r_vld[i-1];
                end
            end
        end
    end

    // Occupancy is the population count of the next valid vector
    always_comb begin
        w_occ_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ_nxt = w_occ_nxt + c_OCC_W'(w_vld_nxt[i]);
        end
    end

    // Valid bits and occupancy register together so they never disagree
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_occ <= '0;
        end else begin
            r_vld <= w_vld_nxt;
            r_occ <= w_occ_nxt;
        end
    end

    // Data words: only real transactions are moved, bubbles leave the
    // destination untouched; flush drops valid bits but keeps data as is
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_res[i] <= '0;
            end
            r_ovf <= '0;
        end else if (!flush) begin
            if (w_accept) begin
                r_res[0] <= w_res;
                r_ovf[0] <= w_carry;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_load[i] && r_vld[i-1]) begin
                    r_res[i] <= r_res[i-1];
                    r_ovf[i] <= r_ovf[i-1];
                end
            end
        end
    end

    // Output side is driven straight from the last stage
    always_comb begin
        out_valid = r_vld[DEPTH-1];
        y         = r_res[DEPTH-1];
        ovf       = r_ovf[DEPTH-1];
        occupancy = r_occ;
    end

endmodule

`default_nettype wire
